// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_pkg
//  Purpose  : Shared types and helpers for the BCD score tracker:
//             blank display code, FSM state encoding, BCD digit type and the
//             packed-digit bit-offset helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

   // Value that the 7-segment driver renders as an unlit digit
   localparam logic [4:0] BLANK_CODE = 5'b10000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      CMP  = 2'd2,
      COPY = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   // Bit offset of BCD digit idx inside a packed score (digit 0 at [3:0])
   function automatic int digit_lsb(input int idx);
      return idx * 4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_scan
//  Purpose  : Time-multiplexes the high score and current score onto one
//             7-segment driver. Slots 0..DIGITS-1 show the high score (MSD
//             first), slots DIGITS..2*DIGITS-1 show the score (MSD first).
//             Leading zeros are optionally replaced by the blank code.
//  Ports    : clock_100Mhz  - system clock
//             reset         - synchronous, active-high
//             score_bcd     - packed current score, digit 0 in [3:0]
//             high_bcd      - packed high score, same packing
//             scan_idx      - current display slot
//             digit_holder  - registered digit value for the slot (5'b10000 = blank)
//  Revision : 1.0 - initial release
// ============================================================================
module score_display_scan
   import score_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int LEADING_BLANK = 1
) (
   input  logic                          clock_100Mhz,
   input  logic                          reset,
   input  logic [4*DIGITS-1:0]           score_bcd,
   input  logic [4*DIGITS-1:0]           high_bcd,
   output logic [$clog2(2*DIGITS)-1:0]   scan_idx,
   output logic [4:0]                    digit_holder
);

   localparam int SCAN_W = $clog2(2*DIGITS);
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [SCAN_W-1:0] c_slot_last = SCAN_W'(2*DIGITS - 1);

   logic [CNT_W-1:0]  r_refresh_cnt;
   logic [SCAN_W-1:0] r_scan_idx;
   logic [4:0]        r_digit_holder;

   logic [DIGITS-1:0] w_score_blank;
   logic [DIGITS-1:0] w_high_blank;
   logic              w_score_run;
   logic              w_high_run;
   int                w_slot;
   int                w_num_idx;
   logic              w_from_score;
   bcd_t              w_digit;
   logic              w_blank;

   // A digit is blank when it and every more significant digit are zero;
   // the run flag walks down from the MSD. Digit 0 always stays visible.
   always_comb begin
      w_score_blank = '0;
      w_high_blank  = '0;
      w_score_run   = 1'b1;
      w_high_run    = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_score_run      = w_score_run && (score_bcd[digit_lsb(i) +: 4] == 4'd0);
         w_high_run       = w_high_run  && (high_bcd[digit_lsb(i) +: 4]  == 4'd0);
         w_score_blank[i] = w_score_run && (i != 0) && (LEADING_BLANK != 0);
         w_high_blank[i]  = w_high_run  && (i != 0) && (LEADING_BLANK != 0);
      end
   end

   // Slot to (number, digit) mapping: both halves run MSD first
   always_comb begin
      w_slot = int'(r_scan_idx);
      if (w_slot >= DIGITS) begin
         w_from_score = 1'b1;
         w_num_idx    = 2*DIGITS - 1 - w_slot;
         w_digit      = score_bcd[digit_lsb(w_num_idx) +: 4];
         w_blank      = w_score_blank[w_num_idx];
      end else begin
         w_from_score = 1'b0;
         w_num_idx    = DIGITS - 1 - w_slot;
         w_digit      = high_bcd[digit_lsb(w_num_idx) +: 4];
         w_blank      = w_high_blank[w_num_idx];
      end
   end

   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         r_refresh_cnt  <= '0;
         r_scan_idx     <= '0;
         r_digit_holder <= BLANK_CODE;
      end else begin
         r_digit_holder <= w_blank ? BLANK_CODE : {1'b0, w_digit};
         if (r_refresh_cnt == c_cnt_last) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= (r_scan_idx == c_slot_last) ? '0 : r_scan_idx + 1'b1;
         end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
         end
      end
   end

   assign scan_idx     = r_scan_idx;
   assign digit_holder = r_digit_holder;

endmodule
`default_nettype wire

// File: rtl/bcd_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_score_tracker
//  Purpose  : BCD score / high-score engine. Eat events add POINTS through a
//             digit-serial saturating BCD adder, then a digit-serial compare
//             (MSD first) decides whether the high score is replaced. One eat
//             may be queued while busy; further ones are dropped.
//  Ports    : clock_100Mhz  - system clock
//             reset         - synchronous, active-high
//             eat           - pulse: add POINTS
//             clear         - pulse: new game (score and flags cleared)
//             busy          - engine not idle
//             score_bcd     - current score, digit 0 in [3:0]
//             high_bcd      - high score, same packing
//             new_high      - sticky: high score beaten this game
//             drop          - one-cycle pulse: eat discarded
//             scan_idx      - display slot index
//             digit_holder  - 7-seg driver value (5'b10000 = blank)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_score_tracker
   import score_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int POINTS        = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int LEADING_BLANK = 1
) (
   input  logic                          clock_100Mhz,
   input  logic                          reset,
   input  logic                          eat,
   input  logic                          clear,
   output logic                          busy,
   output logic [4*DIGITS-1:0]           score_bcd,
   output logic [4*DIGITS-1:0]           high_bcd,
   output logic                          new_high,
   output logic                          drop,
   output logic [$clog2(2*DIGITS)-1:0]   scan_idx,
   output logic [4:0]                    digit_holder
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(DIGITS - 1);
   localparam logic [4:0]          c_points   = 5'(POINTS);
   localparam logic [4*DIGITS-1:0] c_all_nine = {DIGITS{4'h9}};

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [4*DIGITS-1:0] r_score;
   logic [4*DIGITS-1:0] r_high;
   logic                r_new_high;
   logic                r_pending;
   logic                r_drop;

   int         w_lsb;
   bcd_t       w_score_dig;
   bcd_t       w_high_dig;
   logic [4:0] w_sum;
   logic       w_sum_gt9;
   bcd_t       w_wr_digit;

   // Digit-serial datapath: the same index drives the adder and comparator
   always_comb begin
      w_lsb       = digit_lsb(int'(r_idx));
      w_score_dig = r_score[w_lsb +: 4];
      w_high_dig  = r_high[w_lsb +: 4];
      w_sum       = {1'b0, w_score_dig}
                  + ((r_idx == '0) ? c_points : 5'd0)
                  + {4'd0, r_carry};
      w_sum_gt9   = (w_sum > 5'd9);
      w_wr_digit  = w_sum_gt9 ? 4'(w_sum - 5'd10) : w_sum[3:0];
   end

   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_carry    <= 1'b0;
         r_score    <= '0;
         r_high     <= '0;
         r_new_high <= 1'b0;
         r_pending  <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_drop <= 1'b0;
         if (clear) begin
            // New game wins over everything; a coincident eat is discarded silently
            r_state    <= IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_score    <= '0;
            r_new_high <= 1'b0;
            r_pending  <= 1'b0;
         end else begin
            if ((r_state != IDLE) && eat) begin
               if (r_pending) r_drop    <= 1'b1;
               else           r_pending <= 1'b1;
            end
            case (r_state)
               IDLE: begin
                  if (r_pending || eat) begin
                     r_state   <= ADD;
                     r_idx     <= '0;
                     r_carry   <= 1'b0;
                     // Queued event goes first; a fresh eat here takes its slot
                     r_pending <= r_pending && eat;
                  end
               end
               ADD: begin
                  if (w_sum_gt9 && (r_idx == c_last_idx)) begin
                     r_score <= c_all_nine;
                     r_carry <= 1'b0;
                     r_idx   <= c_last_idx;
                     r_state <= CMP;
                  end else begin
                     r_score[w_lsb +: 4] <= w_wr_digit;
                     r_carry             <= w_sum_gt9;
                     if (w_sum_gt9) begin
                        r_idx <= r_idx + 1'b1;
                     end else begin
                        r_idx   <= c_last_idx;
                        r_state <= CMP;
                     end
                  end
               end
               CMP: begin
                  if (w_score_dig > w_high_dig) begin
                     r_state <= COPY;
                  end else if ((w_score_dig < w_high_dig) || (r_idx == '0)) begin
                     r_state <= IDLE;
                  end else begin
                     r_idx <= r_idx - 1'b1;
                  end
               end
               COPY: begin
                  r_high     <= r_score;
                  r_new_high <= 1'b1;
                  r_state    <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   score_display_scan #(
      .DIGITS        (DIGITS),
      .REFRESH_DIV   (REFRESH_DIV),
      .LEADING_BLANK (LEADING_BLANK)
   ) u_display_scan (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .score_bcd    (r_score),
      .high_bcd     (r_high),
      .scan_idx     (scan_idx),
      .digit_holder (digit_holder)
   );

   assign busy      = (r_state != IDLE);
   assign score_bcd = r_score;
   assign high_bcd  = r_high;
   assign new_high  = r_new_high;
   assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_score_tracker
//  Purpose  : Directed self-checking bench for bcd_score_tracker
//             (DIGITS=4, POINTS=4, REFRESH_DIV=4, LEADING_BLANK=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_score_tracker;

   localparam int DIGITS        = 4;
   localparam int POINTS        = 4;
   localparam int REFRESH_DIV   = 4;
   localparam int LEADING_BLANK = 1;

   logic        clock_100Mhz = 1'b0;
   logic        reset        = 1'b1;
   logic        eat          = 1'b0;
   logic        clear        = 1'b0;
   logic        busy;
   logic [15:0] score_bcd;
   logic [15:0] high_bcd;
   logic        new_high;
   logic        drop;
   logic [2:0]  scan_idx;
   logic [4:0]  digit_holder;

   int n_checks   = 0;
   int n_errors   = 0;
   int drop_seen  = 0;

   bcd_score_tracker #(
      .DIGITS        (DIGITS),
      .POINTS        (POINTS),
      .REFRESH_DIV   (REFRESH_DIV),
      .LEADING_BLANK (LEADING_BLANK)
   ) dut (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .eat          (eat),
      .clear        (clear),
      .busy         (busy),
      .score_bcd    (score_bcd),
      .high_bcd     (high_bcd),
      .new_high     (new_high),
      .drop         (drop),
      .scan_idx     (scan_idx),
      .digit_holder (digit_holder)
   );

   always #5 clock_100Mhz = ~clock_100Mhz;

   always @(negedge clock_100Mhz) begin
      if (!reset && drop === 1'b1) drop_seen++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic eat_once();
      eat = 1'b1;
      @(negedge clock_100Mhz);
      eat = 1'b0;
   endtask

   task automatic clear_once();
      clear = 1'b1;
      @(negedge clock_100Mhz);
      clear = 1'b0;
   endtask

   // Counts busy cycles from the current negedge; an expired bound is a failure
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge clock_100Mhz);
      end
      if (cycles >= 100) begin
         n_checks++;
         n_errors++;
         $error("FAIL idle_timeout observed=busy required=idle");
      end
   endtask

   task automatic eat_n(input int n);
      int c;
      for (int i = 0; i < n; i++) begin
         eat_once();
         wait_idle(c);
      end
   endtask

   initial begin
      int c;
      int g;
      logic [4:0] exp_disp [8];
      exp_disp = '{5'h10, 5'h01, 5'h00, 5'h00, 5'h10, 5'h10, 5'h01, 5'h02};

      // Reset state
      repeat (3) @(negedge clock_100Mhz);
      reset = 1'b0;
      chk("rst_score", 32'(score_bcd), 32'h0);
      chk("rst_high", 32'(high_bcd), 32'h0);
      chk("rst_new_high", 32'(new_high), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_drop", 32'(drop), 32'h0);
      chk("rst_scan_idx", 32'(scan_idx), 32'h0);
      chk("rst_digit", 32'(digit_holder), 32'h10);

      // Three spaced eats
      eat_once();
      chk("busy_after_eat", 32'(busy), 32'h1);
      wait_idle(c);
      chk("first_eat_cycles", 32'(c), 32'd6);
      chk("score_4", 32'(score_bcd), 32'h0004);
      repeat (20) @(negedge clock_100Mhz);
      eat_once();
      wait_idle(c);
      repeat (20) @(negedge clock_100Mhz);
      eat_once();
      wait_idle(c);
      chk("score_12", 32'(score_bcd), 32'h0012);
      chk("high_12", 32'(high_bcd), 32'h0012);
      chk("new_high_12", 32'(new_high), 32'h1);
      chk("no_drop_yet", 32'(drop_seen), 32'd0);

      // Carry ripple 0096 -> 0100: ADD 3, CMP 2, COPY 1
      eat_n(21);
      chk("score_96", 32'(score_bcd), 32'h0096);
      eat_once();
      wait_idle(c);
      chk("ripple_cycles", 32'(c), 32'd6);
      chk("score_100", 32'(score_bcd), 32'h0100);
      chk("high_100", 32'(high_bcd), 32'h0100);

      // New game keeps the high score
      clear_once();
      chk("clr_score", 32'(score_bcd), 32'h0);
      chk("clr_high", 32'(high_bcd), 32'h0100);
      chk("clr_new_high", 32'(new_high), 32'h0);
      chk("clr_busy", 32'(busy), 32'h0);
      eat_n(3);
      chk("disp_score", 32'(score_bcd), 32'h0012);
      chk("disp_high", 32'(high_bcd), 32'h0100);

      // Display scan: align to the first cycle of slot 0
      g = 0;
      while (scan_idx !== 3'd7 && g < 40) begin g++; @(negedge clock_100Mhz); end
      while (scan_idx === 3'd7 && g < 40) begin g++; @(negedge clock_100Mhz); end
      if (g >= 40) begin
         n_checks++;
         n_errors++;
         $error("FAIL scan_sync observed=%0d required=0", scan_idx);
      end
      for (int k = 0; k < 8; k++) begin
         for (int cy = 0; cy < 4; cy++) begin
            chk($sformatf("scan_k%0d_c%0d", k, cy), 32'(scan_idx), 32'(k));
            chk($sformatf("disp_k%0d_c%0d", k, cy), 32'(digit_holder),
                32'((cy == 0) ? exp_disp[(k + 7) % 8] : exp_disp[k]));
            @(negedge clock_100Mhz);
         end
      end

      // Equal score does not beat the high score; one more does
      clear_once();
      eat_n(25);
      chk("eq_score", 32'(score_bcd), 32'h0100);
      chk("eq_high", 32'(high_bcd), 32'h0100);
      chk("eq_new_high", 32'(new_high), 32'h0);
      eat_n(1);
      chk("beat_score", 32'(score_bcd), 32'h0104);
      chk("beat_high", 32'(high_bcd), 32'h0104);
      chk("beat_new_high", 32'(new_high), 32'h1);

      // Queue: three consecutive eats -> process, pend, drop
      clear_once();
      eat = 1'b1;
      repeat (3) @(negedge clock_100Mhz);
      eat = 1'b0;
      chk("drop_pulse", 32'(drop), 32'h1);
      @(negedge clock_100Mhz);
      chk("drop_one_cycle", 32'(drop), 32'h0);
      chk("idle_gap", 32'(busy), 32'h0);
      @(negedge clock_100Mhz);
      chk("pending_start", 32'(busy), 32'h1);
      wait_idle(c);
      chk("queue_score", 32'(score_bcd), 32'h0008);
      chk("queue_high", 32'(high_bcd), 32'h0104);
      chk("queue_drops", 32'(drop_seen), 32'd1);

      // Saturation
      eat_n(2497);
      chk("score_9996", 32'(score_bcd), 32'h9996);
      eat_once();
      wait_idle(c);
      chk("sat_cycles", 32'(c), 32'd9);
      chk("sat_score", 32'(score_bcd), 32'h9999);
      chk("sat_high", 32'(high_bcd), 32'h9999);
      chk("sat_new_high", 32'(new_high), 32'h1);
      eat_once();
      wait_idle(c);
      chk("sat2_cycles", 32'(c), 32'd8);
      chk("sat2_score", 32'(score_bcd), 32'h9999);

      // Clear mid-ADD, then clear coincident with eat
      eat_once();
      clear_once();
      chk("midadd_busy", 32'(busy), 32'h0);
      chk("midadd_score", 32'(score_bcd), 32'h0);
      chk("midadd_high", 32'(high_bcd), 32'h9999);
      chk("midadd_new_high", 32'(new_high), 32'h0);
      eat = 1'b1;
      clear = 1'b1;
      @(negedge clock_100Mhz);
      eat = 1'b0;
      clear = 1'b0;
      chk("coinc_busy", 32'(busy), 32'h0);
      chk("coinc_drop", 32'(drop), 32'h0);
      @(negedge clock_100Mhz);
      chk("coinc_still_idle", 32'(busy), 32'h0);
      chk("coinc_score", 32'(score_bcd), 32'h0);
      chk("final_drops", 32'(drop_seen), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
